// File: rtl/ysyx_22041207_mem_arbiter_pkg.sv
// Shared encodings for the IF/MEM data-bus arbiter: FSM states, owners and access sizes.
package ysyx_22041207_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StRsp  = 2'd2,
    StDone = 2'd3
  } state_e;

  typedef enum logic {
    OwnerIf  = 1'b0,
    OwnerMem = 1'b1
  } owner_e;

  localparam logic [7:0] SizeB = 8'd1;
  localparam logic [7:0] SizeH = 8'd2;
  localparam logic [7:0] SizeW = 8'd4;
  localparam logic [7:0] SizeD = 8'd8;

endpackage

// File: rtl/ysyx_22041207_mem_arbiter_rr_arb2.sv
// Two-way grant between IF and MEM; on contention a pointer decides (FAIR=1) or MEM wins (FAIR=0).
module ysyx_22041207_rr_arb2 #(
  parameter bit FAIR = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic req_if,
  input  logic req_mem,
  input  logic advance,
  output logic grant_if,
  output logic grant_mem
);

  logic favour_mem_q, favour_mem_d;

  always_comb begin
    grant_mem    = req_mem && (!req_if || !FAIR || favour_mem_q);
    grant_if     = req_if && !grant_mem;
    // After a grant the pointer favours whoever did not win.
    favour_mem_d = advance ? grant_if : favour_mem_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      favour_mem_q <= 1'b1;
    end else begin
      favour_mem_q <= favour_mem_d;
    end
  end

endmodule

// File: rtl/ysyx_22041207_mem_arbiter.sv
// Shares one bus master port between IF (reads) and MEM (loads/stores), one transaction at a time.
module ysyx_22041207_mem_arbiter
  import ysyx_22041207_mem_arbiter_pkg::*;
#(
  parameter int unsigned AW   = 64,
  parameter int unsigned DW   = 64,
  parameter bit          FAIR = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_valid,
  output logic            if_req_ready,
  input  logic [AW-1:0]   if_addr,
  output logic            if_rsp_valid,
  input  logic            if_rsp_ready,
  output logic [DW-1:0]   if_rdata,
  input  logic            mem_req_valid,
  output logic            mem_req_ready,
  input  logic            mem_req_wr,
  input  logic [AW-1:0]   mem_addr,
  input  logic [7:0]      mem_size,
  input  logic [DW-1:0]   mem_wdata,
  input  logic [DW/8-1:0] mem_wmask,
  output logic            mem_rsp_valid,
  input  logic            mem_rsp_ready,
  output logic [DW-1:0]   mem_rdata,
  output logic            bus_req_valid,
  input  logic            bus_req_ready,
  output logic            bus_req_wr,
  output logic [AW-1:0]   bus_addr,
  output logic [7:0]      bus_size,
  output logic [DW-1:0]   bus_wdata,
  output logic [DW/8-1:0] bus_wmask,
  input  logic            bus_rsp_valid,
  output logic            bus_rsp_ready,
  input  logic [DW-1:0]   bus_rdata
);

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      size_q, size_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW/8-1:0] wmask_q, wmask_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic grant_if, grant_mem;
  logic idle, accept, owner_rsp_ready;

  // Ready is gated by rst so nothing is accepted in a cycle the reset will discard.
  assign idle   = (state_q == StIdle) && !rst;
  assign accept = idle && (grant_if || grant_mem);

  ysyx_22041207_rr_arb2 #(
    .FAIR (FAIR)
  ) u_rr_arb2 (
    .clk       (clk),
    .rst       (rst),
    .req_if    (if_req_valid),
    .req_mem   (mem_req_valid),
    .advance   (accept),
    .grant_if  (grant_if),
    .grant_mem (grant_mem)
  );

  assign owner_rsp_ready = (owner_q == OwnerMem) ? mem_rsp_ready : if_rsp_ready;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StReq;
          if (grant_mem) begin
            owner_d = OwnerMem;
            wr_d    = mem_req_wr;
            addr_d  = mem_addr;
            size_d  = mem_size;
            wdata_d = mem_wdata;
            wmask_d = mem_req_wr ? mem_wmask : '0;
          end else begin
            owner_d = OwnerIf;
            wr_d    = 1'b0;
            addr_d  = if_addr;
            size_d  = SizeW;
            wdata_d = '0;
            wmask_d = '0;
          end
        end
      end
      StReq: begin
        if (bus_req_ready) state_d = StRsp;
      end
      StRsp: begin
        if (bus_rsp_valid) begin
          rdata_d = wr_q ? '0 : bus_rdata;
          state_d = StDone;
        end
      end
      StDone: begin
        if (owner_rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= OwnerIf;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
    end
  end

  assign if_req_ready  = idle && grant_if;
  assign mem_req_ready = idle && grant_mem;

  assign bus_req_valid = (state_q == StReq);
  assign bus_req_wr    = wr_q;
  assign bus_addr      = addr_q;
  assign bus_size      = size_q;
  assign bus_wdata     = wdata_q;
  assign bus_wmask     = wmask_q;
  assign bus_rsp_ready = (state_q == StRsp);

  assign if_rsp_valid  = (state_q == StDone) && (owner_q == OwnerIf);
  assign mem_rsp_valid = (state_q == StDone) && (owner_q == OwnerMem);
  assign if_rdata      = rdata_q;
  assign mem_rdata     = rdata_q;

endmodule
